// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and defaults for the round-robin multiplexing arbiter.
package rr_mux_arbiter_pkg;

  // Arbiter control states; codes 2 and 3 are treated as IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1
  } state_t;

  localparam int DEF_N     = 4;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_SRC_W = $clog2(DEF_N);

  // Width of a requester index; never narrower than one bit.
  function automatic int src_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// Rotating priority search: first requester at or after ptr, modulo N.
module rr_pick
  import rr_mux_arbiter_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int SRC_W = src_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SRC_W-1:0] ptr,
  output logic [SRC_W-1:0] winner,
  output logic             any_req
);

  // Walk offsets from farthest to nearest so the nearest active request wins.
  always_comb begin
    int idx;
    idx     = 0;
    winner  = '0;
    any_req = |req;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) winner = SRC_W'(idx);
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter feeding one registered multiplexer output.
// Handshake: a transfer is held on out_data/out_src while out_valid is high
// and completes on the rising edge where out_valid and out_ready are both
// high; out_data/out_src never change while out_valid is high and
// out_ready is low. grant is a combinational one-cycle pulse in the IDLE
// cycle whose edge captures the winner's data.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int  N     = DEF_N,
  parameter int  WIDTH = DEF_WIDTH,
  localparam int SRC_W = src_width(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] data_in,
  output logic [N-1:0]       grant,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SRC_W-1:0]   out_src,
  input  logic               out_ready,
  output logic               busy,
  output logic [1:0]         dbg_state,
  output logic [SRC_W-1:0]   dbg_ptr
);

  state_t            state, state_next;
  logic [SRC_W-1:0]  ptr;
  logic [SRC_W-1:0]  winner;
  logic              any_req;
  logic              capture;
  logic              done;
  logic [SRC_W-1:0]  ptr_after;

  rr_pick #(.N(N), .SRC_W(SRC_W)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  // Pointer moves to the requester after the one just served, wrapping at N-1.
  assign ptr_after = (out_src == SRC_W'(N - 1)) ? '0 : out_src + SRC_W'(1);

  // Next-state and grant decode; grant is suppressed while reset is applied.
  always_comb begin
    state_next = state;
    grant      = '0;
    capture    = 1'b0;
    done       = 1'b0;
    case (state)
      SEND: begin
        if (out_ready) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        if (any_req) begin
          capture       = 1'b1;
          grant[winner] = 1'b1;
          state_next    = SEND;
        end
      end
    endcase
    if (!rst_n) grant = '0;
  end

  // State, pointer and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      out_data <= '0;
      out_src  <= '0;
    end else begin
      state <= state_next;
      if (capture) begin
        out_data <= data_in[int'(winner)*WIDTH +: WIDTH];
        out_src  <= winner;
      end
      if (done) ptr <= ptr_after;
    end
  end

  assign out_valid = (state == SEND);
  assign busy      = (state == SEND);
  assign dbg_state = state;
  assign dbg_ptr   = ptr;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed and random stimulus for rr_mux_arbiter against a transfer-level model.
module tb_rr_mux_arbiter;
  import rr_mux_arbiter_pkg::*;

  localparam int N = 4;
  localparam int W = 32;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N*W-1:0]   data_in = '0;
  logic             out_ready = 1'b0;
  logic [N-1:0]     grant;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [1:0]       out_src;
  logic             busy;
  logic [1:0]       dbg_state;
  logic [1:0]       dbg_ptr;

  rr_mux_arbiter #(.N(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data_in   (data_in),
    .grant     (grant),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .busy      (busy),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  int total = 0;
  int bad   = 0;

  // reference model: one pending transfer, pointer, held data/source
  bit           m_active = 1'b0;
  int           m_ptr    = 0;
  int           m_src    = 0;
  logic [W-1:0] m_data   = '0;
  logic [W-1:0] exp_q[$];
  int           gq[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // first requesting index found scanning p, p+1, ... modulo N
  function automatic int model_pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++)
      if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic set_data(input int i, input logic [W-1:0] v);
    data_in[i*W +: W] = v;
  endtask

  // driver: one clock cycle with given reset/request/ready, checked both sides of the edge
  task automatic step(input logic rn, input logic [N-1:0] r, input logic rdy);
    int w;
    logic [N-1:0] eg;
    @(negedge clk);
    rst_n = rn; req = r; out_ready = rdy;
    #1;
    w  = model_pick(r, m_ptr);
    eg = '0;
    if (rn && !m_active && w >= 0) eg[w] = 1'b1;
    check("grant", grant, eg);
    check("busy_pre", busy, m_active);
    check("valid_pre", out_valid, m_active);
    if (eg != 0) gq.push_back(w);
    if (rn && m_active && rdy) begin
      check("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("sb_data", out_data, exp_q.pop_front());
    end
    @(posedge clk);
    if (!rn) begin
      m_active = 1'b0; m_ptr = 0; m_src = 0; m_data = '0;
      exp_q.delete();
    end else if (!m_active) begin
      if (w >= 0) begin
        m_active = 1'b1; m_src = w; m_data = data_in[w*W +: W];
        exp_q.push_back(m_data);
      end
    end else if (rdy) begin
      m_active = 1'b0;
      m_ptr    = (m_src + 1) % N;
    end
    #1;
    check("valid", out_valid, m_active);
    check("busy", busy, m_active);
    check("state", dbg_state, m_active ? 2'(SEND) : 2'(IDLE));
    check("data", out_data, m_data);
    check("src", out_src, m_src);
    check("ptr", dbg_ptr, m_ptr);
  endtask

  initial begin
    logic [N-1:0] r;
    // reset held two cycles with every requester active
    for (int i = 0; i < N; i++) set_data(i, 32'h1000_0000 + i);
    step(1'b0, 4'b1111, 1'b0);
    step(1'b0, 4'b1111, 1'b0);
    check("rst_data", out_data, 0);

    // single request from requester 2
    set_data(2, 32'hDEAD_BEEF);
    gq.delete();
    step(1'b1, 4'b0100, 1'b1);
    check("single_grant", gq.size() == 1 && gq[0] == 2, 1);
    check("single_data", out_data, 32'hDEAD_BEEF);
    check("single_src", out_src, 2);
    step(1'b1, 4'b0000, 1'b1);
    check("single_ptr", dbg_ptr, 3);
    step(1'b1, 4'b0000, 1'b1);

    // round robin from a fresh reset: expect 0,1,2,3,0
    step(1'b0, 4'b0000, 1'b0);
    gq.delete();
    for (int i = 0; i < 10; i++) step(1'b1, 4'b1111, 1'b1);
    check("rr_count", gq.size(), 5);
    for (int i = 0; i < 5 && i < gq.size(); i++) check("rr_order", gq[i], i % N);

    // backpressure: hold for 5 cycles while data and requests churn
    step(1'b1, 4'b0000, 1'b1);
    set_data(0, 32'hCAFE_0000);
    step(1'b1, 4'b0001, 1'b0);
    for (int i = 0; i < 5; i++) begin
      set_data(0, $urandom);
      set_data(1, $urandom);
      step(1'b1, 4'($urandom_range(0, 15)), 1'b0);
      check("bp_data", out_data, 32'hCAFE_0000);
      check("bp_src", out_src, 0);
    end
    step(1'b1, 4'b0000, 1'b1);
    check("bp_done", out_valid, 0);

    // wrap-around: serve requester 2 to park ptr at 3, then 4'b1001
    step(1'b1, 4'b0100, 1'b1);
    step(1'b1, 4'b0000, 1'b1);
    check("wrap_ptr", dbg_ptr, 3);
    gq.delete();
    for (int i = 0; i < 4; i++) step(1'b1, 4'b1001, 1'b1);
    check("wrap_count", gq.size(), 2);
    if (gq.size() == 2) begin
      check("wrap_first", gq[0], 3);
      check("wrap_second", gq[1], 0);
    end

    // reset during SEND aborts the transfer
    step(1'b1, 4'b0100, 1'b0);
    step(1'b0, 4'b0100, 1'b0);
    check("abort_valid", out_valid, 0);
    check("abort_ptr", dbg_ptr, 0);
    gq.delete();
    step(1'b1, 4'b1010, 1'b1);
    check("abort_next", gq.size() == 1 && gq[0] == 1, 1);

    // random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) set_data($urandom_range(0, N - 1), $urandom);
      r = 4'($urandom_range(0, 15));
      step($urandom_range(0, 49) != 0, r, $urandom_range(0, 2) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
